// File: rtl/vec_pkg.sv
// Shared definitions for the vector item units: default geometry, the
// streamer state encoding and width helpers for index/count fields.
package vec_pkg;

    localparam int VEC_I = 20;
    localparam int VEC_L = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    // Two extra bits so one command can emit more than I items (repeats allowed).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 2;
    endfunction

endpackage

// File: rtl/vec_item_mux.sv
// Parametrised I-to-1 item selector; any index past the end selects item I-1.
module vec_item_mux
    import vec_pkg::*;
#(
    parameter int I  = VEC_I,
    parameter int L  = VEC_L,
    parameter int AW = idx_width(I)
) (
    input  logic [I-1:0][L-1:0] vec_i,
    input  logic [AW-1:0]       sel_i,
    output logic [L-1:0]        item_o
);

    always_comb begin
        item_o = vec_i[I-1];
        if ({1'b0, sel_i} < (AW+1)'(I))
            item_o = vec_i[sel_i];
    end

endmodule

// File: rtl/vector_item_streamer.sv
// Snapshots a vector on start and streams base/stride/count-addressed items
// over a valid/ready interface, with abort and a one-cycle done pulse.
module vector_item_streamer
    import vec_pkg::*;
#(
    parameter  int I  = VEC_I,
    parameter  int L  = VEC_L,
    localparam int AW = idx_width(I),
    localparam int CW = cnt_width(I)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [I-1:0][L-1:0]  vector_in,
    input  logic [AW-1:0]        base,
    input  logic [AW-1:0]        stride,
    input  logic [CW-1:0]        count,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [L-1:0]         out_item,
    output logic [AW-1:0]        out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    state_e               state_q;
    logic [I-1:0][L-1:0]  buf_q;
    logic [AW-1:0]        idx_q, stride_q;
    logic [CW-1:0]        rem_q;
    logic                 valid_q, last_q, busy_q, done_q;

    logic [AW:0]          idx_sum;
    logic [AW-1:0]        idx_d, base_clamp, stride_mod;
    logic                 xfer;

    // Comparisons run at AW+1 bits so a power-of-two I still compares correctly.
    always_comb begin
        idx_sum    = {1'b0, idx_q} + {1'b0, stride_q};
        idx_d      = idx_sum[AW-1:0];
        if (idx_sum >= (AW+1)'(I))
            idx_d = AW'(idx_sum - (AW+1)'(I));
        stride_mod = stride;
        if ({1'b0, stride} >= (AW+1)'(I))
            stride_mod = AW'({1'b0, stride} - (AW+1)'(I));
        base_clamp = base;
        if ({1'b0, base} >= (AW+1)'(I))
            base_clamp = AW'(I - 1);
        xfer = valid_q && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            idx_q    <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        buf_q    <= vector_in;
                        stride_q <= stride_mod;
                        idx_q    <= base_clamp;
                        rem_q    <= count;
                        busy_q   <= 1'b1;
                        if (count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_STREAM;
                            valid_q <= 1'b1;
                            last_q  <= (count == CW'(1));
                        end
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (xfer) begin
                        idx_q <= idx_d;
                        rem_q <= rem_q - 1'b1;
                        if (last_q) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            last_q <= (rem_q == CW'(2));
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    vec_item_mux #(.I(I), .L(L), .AW(AW)) u_mux (
        .vec_i  (buf_q),
        .sel_i  (idx_q),
        .item_o (out_item)
    );

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vector_item_streamer.sv
// Directed bench for vector_item_streamer: a queue-based reference model checked
// every cycle, plus literal expectations on the directed scenarios.
module tb_vector_item_streamer;

    localparam int I  = 20;
    localparam int L  = 32;
    localparam int AW = 5;
    localparam int CW = 7;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [I-1:0][L-1:0] vec;
    logic [AW-1:0]       base = '0;
    logic [AW-1:0]       stride = '0;
    logic [CW-1:0]       count = '0;
    logic                abort = 1'b0;
    logic                out_ready = 1'b1;
    logic                out_valid, out_last, busy, done;
    logic [L-1:0]        out_item;
    logic [AW-1:0]       out_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vector_item_streamer dut (
        .clk(clk), .rst(rst), .start(start), .vector_in(vec),
        .base(base), .stride(stride), .count(count), .abort(abort),
        .out_ready(out_ready), .out_valid(out_valid), .out_item(out_item),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected item list computed as (base + k*stride) mod I.
    typedef struct {
        int          idx;
        logic [L-1:0] item;
        bit          last;
    } ent_t;

    ent_t q[$];
    int   phase = 0;   // 0 idle, 1 streaming, 2 done
    bit   done_exp = 0;
    bit   armed = 0;

    always @(posedge clk) begin
        armed = 1;
        if (rst) begin
            phase = 0;
            q.delete();
            done_exp = 0;
        end else begin
            case (phase)
                0: begin
                    done_exp = 0;
                    if (start) begin
                        int b, s;
                        b = (int'(base) >= I) ? I - 1 : int'(base);
                        s = int'(stride) % I;
                        q.delete();
                        for (int k = 0; k < int'(count); k++) begin
                            ent_t e;
                            e.idx  = (b + k * s) % I;
                            e.item = vec[e.idx];
                            e.last = (k == int'(count) - 1);
                            q.push_back(e);
                        end
                        if (count == 0) begin
                            phase = 2;
                            done_exp = 1;
                        end else begin
                            phase = 1;
                        end
                    end
                end
                1: begin
                    if (abort) begin
                        q.delete();
                        phase = 0;
                    end else if (out_ready) begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin
                            phase = 2;
                            done_exp = 1;
                        end
                    end
                end
                default: begin
                    done_exp = 0;
                    phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("valid", out_valid, (phase == 1));
            chk("busy", busy, (phase != 0));
            chk("done", done, done_exp);
            if (phase == 1 && q.size() > 0) begin
                chk("idx", out_idx, q[0].idx);
                chk("item", out_item, q[0].item);
                chk("last", out_last, q[0].last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int b, input int s, input int c);
        base = AW'(b);
        stride = AW'(s);
        count = CW'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && (phase != 0 || busy); c++) tick();
        chk("idle_timeout", busy, 0);
    endtask

    task automatic set_vec();
        for (int k = 0; k < I; k++) vec[k] = L'(k * 16);
    endtask

    initial begin
        set_vec();
        // 1: reset held two cycles with start high
        start = 1'b1;
        base = 0; stride = 1; count = 2;
        for (int r = 0; r < 2; r++) begin
            tick();
            @(negedge clk);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_idx", out_idx, 0);
            chk("rst_item", out_item, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("first_start_valid", out_valid, 1);
        chk("first_start_idx", out_idx, 0);
        wait_idle();

        // 2: sequential stream
        out_ready = 1'b1;
        cmd(3, 1, 4);
        @(negedge clk); chk("seq0", out_item, 48); chk("seq0_last", out_last, 0);
        tick(); @(negedge clk); chk("seq1", out_item, 64); chk("seq1_last", out_last, 0);
        tick(); @(negedge clk); chk("seq2", out_item, 80); chk("seq2_last", out_last, 0);
        tick(); @(negedge clk); chk("seq3", out_item, 96); chk("seq3_last", out_last, 1);
        tick(); @(negedge clk); chk("seq_done", done, 1); chk("seq_busy5", busy, 1);
        tick(); @(negedge clk); chk("seq_busy6", busy, 0); chk("seq_done6", done, 0);

        // 3: wrap and clamp
        cmd(18, 3, 3);
        @(negedge clk); chk("wrap0", out_idx, 18);
        tick(); @(negedge clk); chk("wrap1", out_idx, 1);
        tick(); @(negedge clk); chk("wrap2", out_idx, 4);
        wait_idle();
        cmd(25, 1, 1);
        @(negedge clk); chk("clamp_idx", out_idx, 19); chk("clamp_item", out_item, 304);
        chk("clamp_last", out_last, 1);
        wait_idle();

        // 4: backpressure while the source vector is rewritten
        out_ready = 1'b0;
        cmd(5, 2, 3);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < I; k++) vec[k] = ~vec[k];
            @(negedge clk);
            chk("bp_item", out_item, 80);
            chk("bp_idx", out_idx, 5);
            chk("bp_valid", out_valid, 1);
            tick();
        end
        vec[7] = 32'hdeadbeef;
        out_ready = 1'b1;
        @(negedge clk); chk("bp0", out_item, 80);
        tick(); @(negedge clk); chk("bp1", out_item, 112);
        tick(); @(negedge clk); chk("bp2", out_item, 144); chk("bp2_last", out_last, 1);
        wait_idle();
        set_vec();

        // 5: count=0, then a start during STREAM is ignored
        cmd(4, 1, 0);
        @(negedge clk); chk("zero_valid", out_valid, 0); chk("zero_done", done, 1);
        wait_idle();
        cmd(0, 4, 3);
        start = 1'b1; base = 9; count = 1;
        @(negedge clk); chk("ign0", out_idx, 0);
        tick(); start = 1'b0;
        @(negedge clk); chk("ign1", out_idx, 4);
        tick(); @(negedge clk); chk("ign2", out_idx, 8);
        wait_idle();

        // 6: abort after two transfers, then a fresh command
        cmd(2, 5, 6);
        @(negedge clk); chk("ab0", out_idx, 2);
        tick(); @(negedge clk); chk("ab1", out_idx, 7);
        tick();
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk); chk("ab2", out_idx, 12);
        tick();
        abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ab_valid", out_valid, 0); chk("ab_busy", busy, 0); chk("ab_done", done, 0);
        cmd(10, 1, 2);
        @(negedge clk); chk("re0", out_idx, 10);
        tick(); @(negedge clk); chk("re1", out_idx, 11); chk("re1_last", out_last, 1);
        wait_idle();

        // extras: stride 0, stride >= I, abort with a coincident transfer,
        // abort in IDLE, abort together with start in IDLE
        cmd(1, 0, 3);
        @(negedge clk); chk("s0_item", out_item, 16);
        wait_idle();
        cmd(0, 23, 3);
        tick(); @(negedge clk); chk("s23_idx", out_idx, 3);
        wait_idle();
        cmd(0, 1, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk); chk("abx_valid", out_valid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        abort = 1'b1;
        cmd(6, 1, 2);
        abort = 1'b0;
        @(negedge clk); chk("abst_valid", out_valid, 1); chk("abst_idx", out_idx, 6);
        wait_idle();

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
